// File: rtl/uart_cmd_rx_pkg.sv
// Shared constants, state encodings and checksum helper for the UART command path.
package uart_cmd_rx_pkg;

  localparam logic [7:0] CMD_HDR   = 8'h55;
  localparam logic [7:0] CMD_START = 8'h01;
  localparam logic [7:0] CMD_GATE  = 8'h02;

  typedef enum logic [2:0] {S_HDR, S_CMD, S_AH, S_AL, S_CHK} parse_state_e;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  function automatic logic [7:0] frame_chk(input logic [7:0] cmd, input logic [7:0] arg_h,
                                           input logic [7:0] arg_l);
    return cmd ^ arg_h ^ arg_l;
  endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// Line input and command outputs of the UART command receiver.
interface uart_cmd_rx_if;
  logic        RX_Pin_In;
  logic        start_pulse;
  logic [15:0] gate_val;
  logic        gate_upd;
  logic        frame_err;
  logic        busy;

  modport master (
    input  RX_Pin_In,
    output start_pulse, gate_val, gate_upd, frame_err, busy
  );

  modport slave (
    output RX_Pin_In,
    input  start_pulse, gate_val, gate_upd, frame_err, busy
  );
endinterface

// File: rtl/uart_cmd_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling, stop-bit check.
module uart_cmd_rx_byte
  import uart_cmd_rx_pkg::*;
#(
  parameter int unsigned BIT_CYC = 868
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_in,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int unsigned CNT_W = $clog2(BIT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYC / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             meta_q, sync_q, prev_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             valid_q, valid_d, ferr_q, ferr_d;
  logic             tick, half_tick;

  assign tick      = (cnt_q == CNT_LAST);
  assign half_tick = (cnt_q == CNT_HALF);

  // Synchroniser and previous-sample flop for falling-edge detection; reset to line idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Receiver state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  // Receiver next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (prev_q && !sync_q) state_d = RX_START;
      RX_START: if (half_tick) state_d = sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (tick) state_d = sync_q ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (sync_q) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Receiver outputs: result of the stop-bit sample.
  always_comb begin
    valid_d = (state_q == RX_STOP) && tick && sync_q;
    ferr_d  = (state_q == RX_STOP) && tick && !sync_q;
  end

  // Baud counter restarts on every state change and after each full bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      if (state_q != state_d || tick || state_q == RX_IDLE || state_q == RX_WAIT) cnt_q <= '0;
      else cnt_q <= cnt_q + CNT_ONE;
      if (state_q != RX_DATA) begin
        bit_q <= '0;
      end else if (tick) begin
        bit_q   <= bit_q + 3'd1;
        shift_q <= {sync_q, shift_q[7:1]};
      end
    end
  end

  assign rx_valid = valid_q;
  assign rx_data  = shift_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_cmd_rx.sv
// Command frame parser: 55 CMD ARG_H ARG_L CHK -> start pulse or gate-time update.
module uart_cmd_rx
  import uart_cmd_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 40,
  parameter logic [15:0] GATE_DEFAULT = 16'd1000
) (
  input logic           CLK,
  input logic           RST,
  uart_cmd_rx_if.master bus
);

  localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
  localparam int unsigned TO_CYC  = TIMEOUT_BITS * BIT_CYC;
  localparam int unsigned TO_W    = $clog2(TO_CYC + 1);
  // Count includes the rx_valid cycle, so the registered error lands TO_CYC cycles later.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic        rx_valid, rx_ferr;
  logic [7:0]  rx_data;

  parse_state_e    state_q, state_d;
  logic [7:0]      cmd_q, arg_h_q, arg_l_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            timeout;
  logic            start_q, start_d, upd_q, upd_d, err_q, err_d;
  logic [15:0]     gate_q, gate_d;

  uart_cmd_rx_byte #(
    .BIT_CYC(BIT_CYC)
  ) u_rx (
    .CLK     (CLK),
    .RST     (RST),
    .rx_in   (bus.RX_Pin_In),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_ferr (rx_ferr)
  );

  assign timeout = (state_q != S_HDR) && !rx_valid && (to_cnt_q == TO_LAST);

  // Parser state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_HDR;
    else     state_q <= state_d;
  end

  // Parser next-state: stop-bit error or timeout abandons the frame.
  always_comb begin
    state_d = state_q;
    if (rx_ferr) begin
      state_d = S_HDR;
    end else if (rx_valid) begin
      unique case (state_q)
        S_HDR:   if (rx_data == CMD_HDR) state_d = S_CMD;
        S_CMD:   state_d = S_AH;
        S_AH:    state_d = S_AL;
        S_AL:    state_d = S_CHK;
        S_CHK:   state_d = S_HDR;
        default: state_d = S_HDR;
      endcase
    end else if (timeout) begin
      state_d = S_HDR;
    end
  end

  // Parser outputs: at most one pulse per cycle by construction of the priority chain.
  always_comb begin
    start_d = 1'b0;
    upd_d   = 1'b0;
    err_d   = 1'b0;
    gate_d  = gate_q;
    if (rx_ferr) begin
      err_d = 1'b1;
    end else if (rx_valid && state_q == S_CHK) begin
      if (rx_data != frame_chk(cmd_q, arg_h_q, arg_l_q)) begin
        err_d = 1'b1;
      end else if (cmd_q == CMD_START) begin
        start_d = 1'b1;
      end else if (cmd_q == CMD_GATE && {arg_h_q, arg_l_q} != 16'd0) begin
        gate_d = {arg_h_q, arg_l_q};
        upd_d  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (timeout) begin
      err_d = 1'b1;
    end
  end

  // Output registers, frame byte capture and inter-byte timeout counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      start_q  <= 1'b0;
      upd_q    <= 1'b0;
      err_q    <= 1'b0;
      gate_q   <= GATE_DEFAULT;
      cmd_q    <= '0;
      arg_h_q  <= '0;
      arg_l_q  <= '0;
      to_cnt_q <= '0;
    end else begin
      start_q <= start_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      gate_q  <= gate_d;
      if (rx_valid && state_q == S_CMD) cmd_q   <= rx_data;
      if (rx_valid && state_q == S_AH)  arg_h_q <= rx_data;
      if (rx_valid && state_q == S_AL)  arg_l_q <= rx_data;
      if (rx_valid)              to_cnt_q <= TO_ONE;
      else if (state_q == S_HDR) to_cnt_q <= '0;
      else                       to_cnt_q <= to_cnt_q + TO_ONE;
    end
  end

  assign bus.start_pulse = start_q;
  assign bus.gate_upd    = upd_q;
  assign bus.frame_err   = err_q;
  assign bus.gate_val    = gate_q;
  assign bus.busy        = (state_q != S_HDR);

endmodule
